// File: rtl/bus_responder_8085_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_responder_8085_if : 8085 multiplexed AD-bus signals seen by a slave   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bus_responder_8085_if;
  logic       ale;
  logic [7:0] ad_in;
  logic [7:0] a_hi;
  logic       io_m;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       ready;
  logic       hit;
  logic       err;

  modport slave (
    input  ale, ad_in, a_hi, io_m, rd_n, wr_n,
    output ad_out, ad_oe, ready, hit, err
  );

  modport master (
    output ale, ad_in, a_hi, io_m, rd_n, wr_n,
    input  ad_out, ad_oe, ready, hit, err
  );
endinterface
`default_nettype wire

// File: rtl/bus_responder_8085.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_responder_8085 : memory-mapped RAM slave on the 8085 AD bus with      |
// | programmable READY wait states. Rev 1.0                                  |
// +--------------------------------------------------------------------------+
module bus_responder_8085 #(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 clk_out,
  input  logic                 reset_out,
  bus_responder_8085_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_WAIT   = 2'd2,
    S_ACCESS = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             ad_out_q, ad_out_d;
  logic                   ad_oe_q, ad_oe_d;
  logic                   ready_q, ready_d;
  logic                   hit_q, hit_d;
  logic                   err_q, err_d;
  logic                   mem_we;

  logic [7:0] mem [2**ADDR_BITS];

  logic [15:0] w_addr;
  logic        w_match;
  logic        w_one_strobe;
  logic        w_both_low;
  logic        w_both_high;

  always_comb begin
    w_addr       = {bus.a_hi, bus.ad_in};
    w_match      = !bus.io_m && (w_addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
    w_one_strobe = bus.rd_n ^ bus.wr_n;
    w_both_low   = !bus.rd_n && !bus.wr_n;
    w_both_high  = bus.rd_n && bus.wr_n;

    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ad_out_d = ad_out_q;
    ad_oe_d  = ad_oe_q;
    ready_d  = ready_q;
    hit_d    = hit_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    // ALE always starts a fresh cycle, abandoning whatever was in flight.
    if (bus.ale) begin
      idx_d   = w_addr[ADDR_BITS-1:0];
      hit_d   = w_match;
      state_d = w_match ? S_ADDR : S_IDLE;
      ready_d = 1'b1;
      ad_oe_d = 1'b0;
    end else if (state_q != S_IDLE && w_both_low) begin
      err_d   = 1'b1;
      ad_oe_d = 1'b0;
      ready_d = 1'b1;
      hit_d   = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (w_one_strobe) begin
            if (WAIT_STATES == 0) begin
              state_d = S_ACCESS;
              if (!bus.rd_n) begin
                ad_out_d = mem[idx_q];
                ad_oe_d  = 1'b1;
              end else begin
                mem_we = 1'b1;
              end
            end else begin
              state_d = S_WAIT;
              cnt_d   = 4'(WAIT_STATES);
              ready_d = 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_both_high) begin
            ready_d = 1'b1;
            hit_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              ready_d = 1'b1;
              state_d = S_ACCESS;
              if (!bus.rd_n) begin
                ad_out_d = mem[idx_q];
                ad_oe_d  = 1'b1;
              end else begin
                mem_we = 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (w_both_high) begin
            ad_oe_d = 1'b0;
            hit_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_out or posedge reset_out) begin
    if (reset_out) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= 4'd0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      ready_q  <= 1'b1;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      ready_q  <= ready_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
    end
  end

  // RAM is deliberately not reset; writes only happen on entry to ACCESS.
  always_ff @(posedge clk_out) begin
    if (mem_we) begin
      mem[idx_q] <= bus.ad_in;
    end
  end

  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.ready  = ready_q;
  assign bus.hit    = hit_q;
  assign bus.err    = err_q;

endmodule
`default_nettype wire
